// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the lab CPU multicycle control sequencer.
package cpu_ctrl_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  // Control FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Next-PC source selected at retire time.
  typedef enum logic {
    PC_SEL_INC    = 1'b0,
    PC_SEL_TARGET = 1'b1
  } pc_sel_t;

  // Opcodes live in IR[7:4].
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_LOAD   = 4'h2;
  localparam logic [3:0] OP_STORE  = 4'h3;
  localparam logic [3:0] OP_MOVI   = 4'h4;
  localparam logic [3:0] OP_UNUSED = 4'h5;
  localparam logic [3:0] OP_BEQ0   = 4'h6;
  localparam logic [3:0] OP_JUMP   = 4'h7;
  localparam logic [3:0] OP_AND    = 4'h8;
  localparam logic [3:0] OP_OR     = 4'h9;
  localparam logic [3:0] OP_XOR    = 4'hA;
  localparam logic [3:0] OP_SHL    = 4'hB;
  localparam logic [3:0] OP_SHR    = 4'hC;
  localparam logic [3:0] OP_LBL    = 4'hD;
  localparam logic [3:0] OP_HALT   = 4'hE;
  localparam logic [3:0] OP_TBD    = 4'hF;

  // The unassigned opcode executes as a NOP regardless of decoder flags.
  function automatic logic is_nop_op(input logic [7:0] ir);
    return ir[7:4] == OP_UNUSED;
  endfunction

endpackage

// File: rtl/cpu_ctrl_pc_unit.sv
// Program counter register with increment / label-target selection on retire.
module pc_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            retire_i,
  input  pc_sel_t         sel_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next PC: only moves on retire; increment wraps naturally modulo 2^PC_W.
  always_comb begin
    pc_d = pc_q;
    if (retire_i) begin
      if (sel_i == PC_SEL_TARGET) begin
        pc_d = target_i;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Multicycle control FSM: fetch into IR, sequence EXEC/MEM/WB from decoder
// flags, retire with PC redirection, stop on halt.
//
// Handshakes: imem_rd_o is held while in FETCH and the byte is taken on the
// first cycle imem_valid_i is high; dmem_req_o/dmem_we_o are held stable in
// MEM and the access completes on the first cycle dmem_ack_i is high. Valid
// and ack are ignored in every other state.
module cpu_ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  output logic [PC_W-1:0]  imem_addr_o,
  output logic             imem_rd_o,
  input  logic [7:0]       imem_data_i,
  input  logic             imem_valid_i,
  output logic [7:0]       ir_o,
  input  logic             dec_mem_read_i,
  input  logic             dec_mem_write_i,
  input  logic             dec_label_read_i,
  input  logic             dec_reg_write_i,
  input  logic             dec_halt_i,
  input  logic             dec_branch_i,
  input  logic [3:0]       dec_branch_addr_i,
  output logic [3:0]       label_idx_o,
  input  logic [PC_W-1:0]  label_target_i,
  input  logic             alu_zero_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ack_i,
  output logic             reg_we_o,
  output logic [PC_W-1:0]  pc_o,
  output logic             halted_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] instr_count_o,
  output state_t           state_o
);

  state_t           state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             halt_enter;
  pc_sel_t          pc_sel;
  pc_sel_t          flow_sel;
  logic [PC_W-1:0]  pc;

  // Redirect choice for a normally retiring instruction: beq0 taken first, then jump.
  always_comb begin
    flow_sel = PC_SEL_INC;
    if (dec_branch_i && alu_zero_i) begin
      flow_sel = PC_SEL_TARGET;
    end else if (dec_label_read_i && !dec_branch_i) begin
      flow_sel = PC_SEL_TARGET;
    end
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    retire     = 1'b0;
    halt_enter = 1'b0;
    pc_sel     = PC_SEL_INC;
    imem_rd_o  = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    reg_we_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_rd_o = 1'b1;
        if (imem_valid_i) begin
          ir_d    = imem_data_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Halt takes precedence; its other flags are stale and ignored.
        if (dec_halt_i) begin
          halt_enter = 1'b1;
          state_d    = ST_HALT;
        end else if (is_nop_op(ir_q)) begin
          retire  = 1'b1;
          pc_sel  = PC_SEL_INC;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_mem_read_i || dec_mem_write_i) begin
          state_d = ST_MEM;
        end else if (dec_reg_write_i) begin
          state_d = ST_WB;
        end else begin
          retire  = 1'b1;
          pc_sel  = flow_sel;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = dec_mem_write_i;
        if (dmem_ack_i) begin
          if (dec_mem_write_i) begin
            retire  = 1'b1;
            pc_sel  = flow_sel;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_we_o = 1'b1;
        retire   = 1'b1;
        pc_sel   = flow_sel;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Retired-instruction counter, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if ((retire || halt_enter) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, IR and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  pc_unit #(.PC_W(PC_W)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .retire_i (retire),
    .sel_i    (pc_sel),
    .target_i (label_target_i),
    .pc_o     (pc)
  );

  assign imem_addr_o   = pc;
  assign pc_o          = pc;
  assign ir_o          = ir_q;
  assign label_idx_o   = dec_branch_addr_i;
  assign instr_count_o = cnt_q;
  assign halted_o      = (state_q == ST_HALT);
  assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign state_o       = state_q;

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Bench for cpu_ctrl_sequencer: directed program, randomized program, halt
// and reset-during-MEM scenarios, checked by a queue-based scoreboard.
module tb_cpu_ctrl_sequencer;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  imem_addr_o;
  logic        imem_rd_o;
  logic [7:0]  imem_data_i = 8'h00;
  logic        imem_valid_i = 1'b0;
  logic [7:0]  ir_o;
  logic        dec_mem_read_i, dec_mem_write_i, dec_label_read_i;
  logic        dec_reg_write_i, dec_halt_i, dec_branch_i;
  logic [3:0]  dec_branch_addr_i;
  logic [3:0]  label_idx_o;
  logic [7:0]  label_target_i = 8'h00;
  logic        alu_zero_i = 1'b0;
  logic        dmem_req_o, dmem_we_o;
  logic        dmem_ack_i = 1'b0;
  logic        reg_we_o;
  logic [7:0]  pc_o;
  logic        halted_o, busy_o;
  logic [15:0] instr_count_o;
  state_t      state_o;

  // Scoreboard queues: fetch = {latency of previous instr, count, pc}.
  logic [31:0] fetch_q[$];
  logic [7:0]  wb_q[$];
  logic [8:0]  mem_q[$];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          mem_wait = 0;
  int          mreq_cnt = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;
  logic [3:0]  rop;

  cpu_ctrl_sequencer dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .imem_addr_o(imem_addr_o), .imem_rd_o(imem_rd_o),
    .imem_data_i(imem_data_i), .imem_valid_i(imem_valid_i), .ir_o(ir_o),
    .dec_mem_read_i(dec_mem_read_i), .dec_mem_write_i(dec_mem_write_i),
    .dec_label_read_i(dec_label_read_i), .dec_reg_write_i(dec_reg_write_i),
    .dec_halt_i(dec_halt_i), .dec_branch_i(dec_branch_i),
    .dec_branch_addr_i(dec_branch_addr_i), .label_idx_o(label_idx_o),
    .label_target_i(label_target_i), .alu_zero_i(alu_zero_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
    .reg_we_o(reg_we_o), .pc_o(pc_o), .halted_o(halted_o), .busy_o(busy_o),
    .instr_count_o(instr_count_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment decoder ----------------
  // {mem_read, mem_write, label_read, reg_write, halt, branch}. The unused
  // opcode and halt deliberately raise stray flags the sequencer must ignore.
  function automatic logic [5:0] dec_fn(input logic [7:0] ir);
    case (ir[7:4])
      OP_LOAD:   return 6'b100100;
      OP_STORE:  return 6'b010000;
      OP_BEQ0:   return 6'b001001;
      OP_JUMP:   return 6'b001000;
      OP_UNUSED: return 6'b101100;
      OP_HALT:   return 6'b010110;
      OP_TBD:    return 6'b000000;
      default:   return 6'b000100;
    endcase
  endfunction

  assign {dec_mem_read_i, dec_mem_write_i, dec_label_read_i,
          dec_reg_write_i, dec_halt_i, dec_branch_i} = dec_fn(ir_o);
  assign dec_branch_addr_i = ir_o[3:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- data memory responder ----------------
  // Acks on request cycle mem_wait+1; random ack noise while idle.
  always @(negedge clk) begin
    if (dmem_req_o) begin
      dmem_ack_i = (mreq_cnt == mem_wait);
      mreq_cnt++;
    end else begin
      dmem_ack_i = 1'($urandom_range(0, 1));
      mreq_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    start_i = 1'b0;
    imem_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fetch_q.delete();
    wb_q.delete();
    mem_q.delete();
    m_pc = 8'h00;
    m_cnt = 16'h0000;
    fetch_q.push_back(32'h0);
    mon_en = 1'b1;
  endtask

  task automatic check_reset_values();
    chk("rst_pc", pc_o, 0);
    chk("rst_ir", ir_o, 0);
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_count", instr_count_o, 0);
    chk("rst_outs", {imem_rd_o, dmem_req_o, dmem_we_o, reg_we_o, halted_o, busy_o}, 0);
  endtask

  task automatic start_run();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Serve one fetch and advance the reference model for that instruction.
  task automatic exec_instr(input logic [7:0] instr, input int fw, input int mw,
                            input logic zero, input logic [7:0] tgt);
    int t;
    int dur;
    logic mr, mwr, lr, rw, hl, br;
    t = 0;
    while (!imem_rd_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      chk("fetch_timeout", imem_rd_o, 1);
      return;
    end
    imem_valid_i = 1'b0;
    imem_data_i = 8'($urandom);
    alu_zero_i = zero;
    label_target_i = tgt;
    mem_wait = mw;
    repeat (fw) @(negedge clk);
    imem_valid_i = 1'b1;
    imem_data_i = instr;
    start_i = 1'($urandom_range(0, 1));
    {mr, mwr, lr, rw, hl, br} = dec_fn(instr);
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (!hl) begin
      if (instr[7:4] == OP_UNUSED) begin
        dur = 2 + fw;
        m_pc = m_pc + 8'd1;
      end else begin
        dur = 3 + fw;
        if (mr || mwr) begin
          dur = dur + mw + 1;
          mem_q.push_back({mwr, 8'(mw + 1)});
          if (!mwr) begin
            dur = dur + 1;
            wb_q.push_back(instr);
          end
        end else if (rw) begin
          dur = dur + 1;
          wb_q.push_back(instr);
        end
        if ((br && zero) || (lr && !br)) m_pc = tgt;
        else m_pc = m_pc + 8'd1;
      end
      fetch_q.push_back({8'(dur), m_cnt, m_pc});
    end
    @(negedge clk);
    imem_valid_i = 1'($urandom_range(0, 1));
    imem_data_i = 8'($urandom);
    start_i = 1'b0;
  endtask

  task automatic check_halted();
    int t;
    t = 0;
    while (!halted_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("halt_reached", halted_o, 1);
    chk("halt_pc", pc_o, m_pc);
    chk("halt_count", instr_count_o, m_cnt);
    chk("halt_busy", busy_o, 0);
    chk("halt_state", state_o, ST_HALT);
    start_i = 1'b1;
    imem_valid_i = 1'b1;
    imem_data_i = 8'h05;
    repeat (3) @(negedge clk);
    chk("halt_hold", {halted_o, imem_rd_o, busy_o}, 3'b100);
    chk("halt_pc_frozen", pc_o, m_pc);
    chk("halt_count_frozen", instr_count_o, m_cnt);
    start_i = 1'b0;
    imem_valid_i = 1'b0;
    chk("left_fetch", fetch_q.size(), 0);
    chk("left_wb", wb_q.size(), 0);
    chk("left_mem", mem_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  logic        prev_rd = 1'b0;
  logic        in_mem = 1'b0;
  int          mem_len = 0;
  logic [8:0]  cur_mem;
  int          last_fetch = 0;
  logic [31:0] fe;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_rd = 1'b0;
      in_mem = 1'b0;
    end else begin
      if (imem_rd_o && !prev_rd) begin
        if (fetch_q.size() == 0) begin
          chk("fetch_unexpected", 1, 0);
        end else begin
          fe = fetch_q.pop_front();
          chk("fetch_addr", imem_addr_o, fe[7:0]);
          chk("pc_o", pc_o, fe[7:0]);
          chk("instr_count", instr_count_o, fe[23:8]);
          if (fe[31:24] != 0) chk("latency", cyc - last_fetch, fe[31:24]);
        end
        last_fetch = cyc;
      end
      prev_rd = imem_rd_o;
      if (reg_we_o) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
        else chk("wb_ir", ir_o, wb_q.pop_front());
        chk("label_idx", label_idx_o, ir_o[3:0]);
      end
      if (dmem_req_o) begin
        if (!in_mem) begin
          in_mem = 1'b1;
          mem_len = 0;
          if (mem_q.size() == 0) begin
            chk("mem_unexpected", 1, 0);
            cur_mem = 9'h0;
          end else begin
            cur_mem = mem_q.pop_front();
            chk("dmem_we", dmem_we_o, cur_mem[8]);
          end
        end else if (dmem_we_o !== cur_mem[8]) begin
          chk("dmem_we_stable", dmem_we_o, cur_mem[8]);
        end
        mem_len++;
      end else if (in_mem) begin
        in_mem = 1'b0;
        chk("dmem_req_len", mem_len, cur_mem[7:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    do_reset();
    check_reset_values();

    // Directed program.
    start_run();
    exec_instr(8'h05, 0, 0, 1'b0, 8'h00);  // add, 4 cycles
    exec_instr(8'h24, 0, 2, 1'b0, 8'h00);  // load, req held 3 cycles
    exec_instr(8'h31, 1, 0, 1'b0, 8'h00);  // store, no writeback
    exec_instr(8'h63, 0, 0, 1'b1, 8'h20);  // beq0 taken
    exec_instr(8'h63, 0, 0, 1'b0, 8'h20);  // beq0 not taken
    exec_instr(8'h72, 0, 0, 1'b0, 8'h40);  // jump
    exec_instr(8'h7F, 0, 0, 1'b0, 8'hFF);  // jump to last address
    exec_instr(8'h50, 0, 0, 1'b1, 8'h33);  // NOP at FF wraps to 0
    exec_instr(8'hF0, 2, 0, 1'b0, 8'h00);  // no-flag op
    exec_instr(8'hE0, 0, 0, 1'b0, 8'h99);  // halt
    check_halted();

    // Randomized program.
    do_reset();
    check_reset_values();
    start_run();
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      while (rop == OP_HALT) rop = 4'($urandom_range(0, 15));
      exec_instr({rop, 4'($urandom_range(0, 15))}, $urandom_range(0, 2),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    exec_instr(8'hE3, 1, 0, 1'b0, 8'h00);
    check_halted();

    // Reset while a long load is in MEM.
    do_reset();
    check_reset_values();
    start_run();
    exec_instr(8'h05, 0, 0, 1'b0, 8'h00);
    exec_instr(8'h24, 0, 40, 1'b0, 8'h00);
    t = 0;
    while (!dmem_req_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("mem_req_seen", dmem_req_o, 1);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", dmem_req_o, 0);
    check_reset_values();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_ctrl_sequencer.md
Name: cpu_ctrl_sequencer

Overview:
- Multicycle control FSM for the 8-bit lab CPU. Fetches an instruction from instruction memory and latches it in an instruction register (IR) that drives the combinational decoder.
- Sequences the ALU, data-memory and register-writeback phases from the decoder flags, owns the program counter (PC) including branch/jump redirection through the label table, and stops on halt.
- Sits between the imem/dmem ports, the decoder and the register file write enable.

Parameters:
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse; starts execution from IDLE
- imem_addr_o  out  PC_W  fetch address, equal to PC
- imem_rd_o  out  1  fetch request
- imem_data_i  in  8  instruction byte
- imem_valid_i  in  1  instruction byte valid
- ir_o  out  8  latched instruction register, feeds the decoder
- dec_mem_read_i, dec_mem_write_i, dec_label_read_i, dec_reg_write_i, dec_halt_i, dec_branch_i  in  1 each  decoder flags
- dec_branch_addr_i  in  4  label index from the decoder
- label_idx_o  out  4  label table index (combinational lookup)
- label_target_i  in  PC_W  resolved target address
- alu_zero_i  in  1  ALU zero result, used for beq0
- dmem_req_o  out  1  data memory request
- dmem_we_o  out  1  1 = store, 0 = load
- dmem_ack_i  in  1  data memory completion
- reg_we_o  out  1  register file write enable (one-cycle pulse)
- pc_o  out  PC_W  current PC
- halted_o  out  1  high in HALT
- busy_o  out  1  high in any state other than IDLE or HALT
- instr_count_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset values: PC=0, IR=0, state=IDLE, instr_count=0; all request, enable and status outputs 0. Reset wins over every other input, including mid-MEM: dmem_req_o is 0 on the cycle after reset is sampled.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: go to FETCH when start_i=1.
- FETCH:
  - imem_rd_o=1, imem_addr_o=PC.
  - Stay in FETCH while imem_valid_i=0.
  - When imem_valid_i=1, load IR<=imem_data_i and go to DECODE.
  - Minimum one cycle (valid may be high in the same cycle as rd).
- DECODE: one cycle so the decoder outputs settle from IR.
  - dec_halt_i=1: go to HALT. All other decoder flags are ignored because they are stale for halt.
  - IR[7:4]=4'b0101 (unassigned opcode): treated as a NOP. Decoder flags are ignored, PC<=PC+1, return to FETCH.
  - Otherwise go to EXEC.
- EXEC: one cycle. The ALU operates on decoded operands. Exit depends on the flags:
  - dec_mem_read_i or dec_mem_write_i: go to MEM.
  - dec_reg_write_i: go to WB.
  - Otherwise the instruction retires here (PC update, then FETCH).
- MEM:
  - dmem_req_o=1 and dmem_we_o=dec_mem_write_i, held stable until dmem_ack_i=1.
  - On ack: load goes to WB; store retires (then FETCH).
  - dmem_ack_i is ignored outside MEM.
- WB: reg_we_o=1 for exactly one cycle, then the instruction retires (then FETCH).
- Retire is registered on the final cycle of the instruction. The PC update is, in priority order:
  - If dec_branch_i and alu_zero_i: PC<=label_target_i (beq0 taken).
  - Else if dec_label_read_i and not dec_branch_i: PC<=label_target_i (jump).
  - Else PC<=PC+1, wrapping from 2^PC_W-1 to 0.
- label_idx_o=dec_branch_addr_i at all times.
- instr_count_o increments on each retire and when HALT is entered. It saturates at all-ones.
- HALT: halted_o=1. Stays in HALT until reset; start_i is ignored. PC is frozen at the halt instruction's address.
- start_i is ignored in every state other than IDLE. imem_valid_i is ignored outside FETCH.
- Minimum latencies with zero-wait memories:
  - ALU op with writeback: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch or jump: 3 cycles.
  - NOP: 2 cycles.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state enum.
  - Opcode constants (OP_ADD..OP_TBD, OP_UNUSED=4'b0101, OP_HALT=4'b1110).
  - PC_W default.
- Sub-module pc_unit: PC register plus next-PC mux (inc/branch/jump, wrap), with a retire strobe and a select input.

Test Plan:
- Reset, then start_i pulse, imem returns 8'h05 (add) with valid on the same cycle → IR=8'h05; reg_we_o pulses in the 4th cycle; PC 0→1; instr_count=1.
- Load 8'h24 with dmem_ack_i delayed 3 cycles → dmem_req_o held high for 3 cycles, dmem_we_o=0; then reg_we_o pulses once; store 8'h31 → no reg_we_o pulse.
- beq0 8'h63 with label_target_i=8'h20: alu_zero_i=1 → PC=8'h20; alu_zero_i=0 → PC=PC+1.
- Jump 8'h72 with label_target_i=8'h40 → PC=8'h40; NOP 8'h50 at PC=8'hFF → PC wraps to 0 after 2 cycles.
- Halt 8'hE0 → halted_o=1, PC frozen, start_i and imem_valid_i ignored; reset → IDLE, PC=0.
- Reset asserted while in MEM with dmem_req_o=1 → dmem_req_o=0 on the next cycle; state=IDLE; instr_count=0.
